// File: rtl/axi_xbar_pkg.sv
// Shared definitions for the AXI crossbar address-channel blocks.
package axi_xbar_pkg;

  localparam int unsigned QOS_W   = 4;
  localparam int unsigned MAX_REQ = 16;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANTED
  } arb_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot pick of the first set bit at or above ptr, wrapping to bit 0.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] mask,
                                                 input int unsigned      ptr);
    logic [MAX_REQ-1:0] pick;
    logic               found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (!found && mask[i] && (i >= ptr)) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (!found && mask[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axi_xbar_age_ctr.sv
// Per-requester wait counter: clears on demand, saturates at LIMIT, held at 0 when LIMIT is 0.
module axi_xbar_age_ctr #(
  parameter int unsigned LIMIT = 64,
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || (LIMIT == 0)) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != WIDTH'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axi_xbar_addr_arb.sv
// Address-channel arbiter for one crossbar master port: urgent-first, QoS-max,
// then round-robin selection; grant is registered and held until ack.
module axi_xbar_addr_arb
  import axi_xbar_pkg::*;
#(
  parameter int unsigned S_COUNT    = 4,
  parameter int unsigned QOS_ENABLE = 1,
  parameter int unsigned AGE_LIMIT  = 64,
  parameter int unsigned AGE_WIDTH  = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [S_COUNT-1:0]             req,
  input  logic [QOS_W*S_COUNT-1:0]       req_qos,
  input  logic                           ack,
  output logic [S_COUNT-1:0]             grant,
  output logic [clog2_min1(S_COUNT)-1:0] grant_encoded,
  output logic                           grant_valid
);

  localparam int unsigned ENC_W = clog2_min1(S_COUNT);

  arb_state_e           state;
  logic [ENC_W-1:0]     ptr;
  logic [ENC_W-1:0]     ptr_sel;
  logic [ENC_W-1:0]     enc_d;
  logic [AGE_WIDTH-1:0] age [S_COUNT];
  logic [S_COUNT-1:0]   urgent;
  logic [S_COUNT-1:0]   cand;
  logic [S_COUNT-1:0]   grant_d;
  logic [QOS_W-1:0]     qos_max;
  logic                 rearb;

  always_comb begin
    rearb   = 1'b0;
    ptr_sel = ptr;
    if (state == ARB_IDLE) begin
      rearb = 1'b1;
    end else if (!(|(grant & req))) begin
      rearb = 1'b1;
    end else if (ack) begin
      rearb   = 1'b1;
      ptr_sel = (grant_encoded == ENC_W'(S_COUNT - 1)) ? '0 : grant_encoded + 1'b1;
    end

    for (int unsigned i = 0; i < S_COUNT; i++) begin
      urgent[i] = req[i] && (AGE_LIMIT != 0) && (age[i] == AGE_WIDTH'(AGE_LIMIT));
    end
    cand = (|urgent) ? urgent : req;

    qos_max = '0;
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      if (cand[i] && (req_qos[QOS_W*i +: QOS_W] > qos_max)) begin
        qos_max = req_qos[QOS_W*i +: QOS_W];
      end
    end
    if (QOS_ENABLE != 0) begin
      for (int unsigned i = 0; i < S_COUNT; i++) begin
        if (req_qos[QOS_W*i +: QOS_W] != qos_max) begin
          cand[i] = 1'b0;
        end
      end
    end

    // On ack-release the pick already uses the advanced pointer, giving back-to-back grants.
    grant_d = rearb ? S_COUNT'(rr_pick(MAX_REQ'(cand), 32'(ptr_sel))) : grant;

    enc_d = '0;
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      if (grant_d[i]) begin
        enc_d = ENC_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      grant         <= '0;
      grant_encoded <= '0;
      grant_valid   <= 1'b0;
      ptr           <= '0;
    end else begin
      state         <= (|grant_d) ? ARB_GRANTED : ARB_IDLE;
      grant         <= grant_d;
      grant_encoded <= enc_d;
      grant_valid   <= |grant_d;
      ptr           <= ptr_sel;
    end
  end

  for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_age
    axi_xbar_age_ctr #(
      .LIMIT (AGE_LIMIT),
      .WIDTH (AGE_WIDTH)
    ) u_age (
      .clk   (clk),
      .rst   (rst),
      .clr   (!req[gi] || grant_d[gi]),
      .inc   (req[gi]),
      .count (age[gi])
    );
  end

endmodule

// File: tb/tb_axi_xbar_addr_arb.sv
// Scoreboard bench: two arbiter configurations share stimulus; a queue-based reference model predicts grants.
module tb_axi_xbar_addr_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] req_qos = '0;
  logic        ack = 1'b0;

  logic [3:0]  grant_a, grant_b;
  logic [1:0]  enc_a, enc_b;
  logic        valid_a, valid_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int ga;
    int gb;
  } exp_t;
  exp_t exp_q[$];

  // Model state per configuration: 0 = QoS on, age limit 4; 1 = QoS off, aging off.
  int m_g   [2];
  int m_ptr [2];
  int m_age [2][4];

  always #5 clk = ~clk;

  axi_xbar_addr_arb #(
    .S_COUNT    (4),
    .QOS_ENABLE (1),
    .AGE_LIMIT  (4)
  ) dut_a (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_qos       (req_qos),
    .ack           (ack),
    .grant         (grant_a),
    .grant_encoded (enc_a),
    .grant_valid   (valid_a)
  );

  axi_xbar_addr_arb #(
    .S_COUNT    (4),
    .QOS_ENABLE (0),
    .AGE_LIMIT  (0)
  ) dut_b (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_qos       (req_qos),
    .ack           (ack),
    .grant         (grant_b),
    .grant_encoded (enc_b),
    .grant_valid   (valid_b)
  );

  function automatic int model_pick(input int c, input logic [3:0] r, input logic [15:0] q, input int p);
    int lim;
    int mx;
    int v;
    bit any_urg;
    bit cand [4];
    lim = (c == 0) ? 4 : 0;
    any_urg = 0;
    for (int i = 0; i < 4; i++)
      if (r[i] && lim > 0 && m_age[c][i] == lim) any_urg = 1;
    for (int i = 0; i < 4; i++)
      cand[i] = r[i] && (!any_urg || m_age[c][i] == lim);
    if (c == 0) begin
      mx = -1;
      for (int i = 0; i < 4; i++) begin
        v = int'(q[4*i +: 4]);
        if (cand[i] && v > mx) mx = v;
      end
      for (int i = 0; i < 4; i++) begin
        v = int'(q[4*i +: 4]);
        cand[i] = cand[i] && (v == mx);
      end
    end
    for (int k = 0; k < 4; k++)
      if (cand[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic void model_step(input int c, input logic rs, input logic [3:0] r,
                                     input logic [15:0] q, input logic a);
    int lim;
    int g;
    int p;
    bit arb;
    lim = (c == 0) ? 4 : 0;
    if (rs) begin
      m_g[c]   = -1;
      m_ptr[c] = 0;
      for (int i = 0; i < 4; i++) m_age[c][i] = 0;
      return;
    end
    g   = m_g[c];
    p   = m_ptr[c];
    arb = 0;
    if (g < 0) arb = 1;
    else if (!r[g]) arb = 1;
    else if (a) begin
      arb = 1;
      p   = (g + 1) % 4;
    end
    if (arb) g = model_pick(c, r, q, p);
    for (int i = 0; i < 4; i++) begin
      if (lim == 0 || !r[i] || g == i) m_age[c][i] = 0;
      else if (m_age[c][i] < lim) m_age[c][i] = m_age[c][i] + 1;
    end
    m_g[c]   = g;
    m_ptr[c] = p;
  endfunction

  task automatic drive(input logic rs, input logic [3:0] r, input logic [15:0] q, input logic a);
    exp_t e;
    @(negedge clk);
    rst = rs; req = r; req_qos = q; ack = a;
    model_step(0, rs, r, q, a);
    model_step(1, rs, r, q, a);
    e.ga = m_g[0];
    e.gb = m_g[1];
    exp_q.push_back(e);
  endtask

  function automatic void check_out(input string nm, input logic [3:0] g, input logic [1:0] e,
                                    input logic v, input int x);
    logic [3:0] xg;
    logic [1:0] xe;
    xg = (x < 0) ? 4'b0000 : (4'b0001 << x);
    xe = (x < 0) ? 2'd0 : 2'(x);
    total++;
    if (g !== xg || e !== xe || v !== (x >= 0) || !$onehot0(g)) begin
      bad++;
      $display("FAIL %s @%0t: grant=%b enc=%0d valid=%b required grant=%b enc=%0d valid=%b",
               nm, $time, g, e, v, xg, xe, (x >= 0));
    end
  endfunction

  // Directed spot check of a fixed expected grant after the next clock edge.
  task automatic expect_grant(input int which, input logic [3:0] g, input string nm);
    logic [3:0] act;
    @(posedge clk);
    #2;
    act = (which == 0) ? grant_a : grant_b;
    total++;
    if (act !== g) begin
      bad++;
      $display("FAIL %s: grant=%b required=%b", nm, act, g);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_out("sb_a", grant_a, enc_a, valid_a, e.ga);
        check_out("sb_b", grant_b, enc_b, valid_b, e.gb);
      end
    end
  end

  initial begin : stim
    logic [3:0]  r;
    logic [15:0] q;
    for (int c = 0; c < 2; c++) begin
      m_g[c] = -1;
      m_ptr[c] = 0;
      for (int i = 0; i < 4; i++) m_age[c][i] = 0;
    end

    drive(1'b1, 4'b0000, 16'h0000, 1'b0);
    drive(1'b1, 4'b0000, 16'h0000, 1'b0);

    // QoS max then RR tie-break from wrapped pointer
    drive(1'b0, 4'b0110, 16'h0920, 1'b0);
    expect_grant(0, 4'b0100, "qos_max");
    drive(1'b0, 4'b0110, 16'h0990, 1'b1);
    expect_grant(0, 4'b0010, "qos_tie_rr");
    drive(1'b0, 4'b0000, 16'h0000, 1'b0);

    // Abandon and ack-while-idle
    drive(1'b0, 4'b0001, 16'h0000, 1'b0);
    expect_grant(0, 4'b0001, "abandon_setup");
    drive(1'b0, 4'b0000, 16'h0000, 1'b0);
    expect_grant(0, 4'b0000, "abandon_clear");
    drive(1'b0, 4'b0000, 16'h0000, 1'b1);
    expect_grant(0, 4'b0000, "ack_idle");

    // Reset mid-grant
    drive(1'b0, 4'b1000, 16'h0000, 1'b0);
    expect_grant(0, 4'b1000, "rst_setup");
    drive(1'b1, 4'b1000, 16'h0000, 1'b0);
    expect_grant(0, 4'b0000, "rst_mid_grant");
    drive(1'b0, 4'b1000, 16'h0000, 1'b0);
    expect_grant(0, 4'b1000, "post_rst_latency");
    drive(1'b0, 4'b0000, 16'h0000, 1'b0);

    // Back-to-back: ack together with a new request
    drive(1'b0, 4'b0001, 16'h0000, 1'b0);
    expect_grant(0, 4'b0001, "b2b_setup");
    drive(1'b0, 4'b0101, 16'h0000, 1'b1);
    expect_grant(0, 4'b0100, "b2b_new");
    drive(1'b0, 4'b0000, 16'h0000, 1'b0);

    // Pure round-robin on the QoS-off instance, pointer starts at 1
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 4'b1111, 16'h0000, (k % 2) == 0);
      expect_grant(1, 4'b0001 << ((1 + k / 2) % 4), "rr_seq");
    end

    // Aging: low-QoS requester 0 gets through once its wait saturates
    drive(1'b1, 4'b0000, 16'h0000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 4'b0011, 16'h00F0, k > 0);
      expect_grant(0, (k == 4) ? 4'b0001 : 4'b0010, "aging");
    end

    // Randomized traffic
    r = 4'b0000;
    q = 16'h0000;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      if ($urandom_range(0, 7) == 0) q = {2'b00, 2'($urandom), 2'b00, 2'($urandom),
                                          2'b00, 2'($urandom), 2'b00, 2'($urandom)};
      drive($urandom_range(0, 99) == 0, r, q, 1'($urandom));
    end
    drive(1'b0, 4'b0000, 16'h0000, 1'b0);

    repeat (3) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_xbar_addr_arb.md
Name: axi_xbar_addr_arb

Overview:
- Per-master-interface address-channel arbiter for the AXI crossbar.
- Receives one request per slave interface, already address-decoded to this master, and selects one winner by QoS-weighted round-robin, with aging to prevent starvation.
- Holds the grant until the downstream address handshake completes.
- The crossbar instantiates one per master interface for AW and one for AR; its grant drives the address/ID mux.

Parameters:
S_COUNT, 4, number of requesting slave interfaces (1..16)
QOS_ENABLE, 1, 1: arbitrate on aqos first; 0: pure round-robin
AGE_LIMIT, 64, cycles a requester may wait before promotion to urgent; 0 disables aging
AGE_WIDTH, $clog2(AGE_LIMIT+1), per-requester wait counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req  in  S_COUNT  request bit per slave interface
req_qos  in  4*S_COUNT  aqos per requester, field i at [4*i+:4]
ack  in  1  pulse: granted transfer accepted downstream (m_axi_avalid && m_axi_aready)
grant  out  S_COUNT  one-hot grant, registered
grant_encoded  out  $clog2(S_COUNT) (min 1)  index of grant
grant_valid  out  1  grant is nonzero

Behaviour:
- Reset: grant=0, grant_encoded=0, grant_valid=0, RR pointer=0, all age counters=0; state IDLE.
- State IDLE (grant_valid=0):
  - If any req bit is set, compute the winner combinationally and register it.
  - Grant is visible the cycle after req is first seen (latency 1); go to GRANTED.
- State GRANTED:
  - Grant is held stable while req[g] stays high and ack is low.
  - ack=1: release. If any req (including req[g]) remains, re-arbitrate in the same cycle and register the new winner (back-to-back, no bubble); else go to IDLE.
  - req[g] drops without ack: abandon. Grant clears next cycle, no pointer update; re-arbitrate the same way as on ack.
  - ack while IDLE, or while req[g] is low, is ignored (no state change).
- Winner selection, applied to candidates in order:
  1. Urgent set: requesters whose age counter equals AGE_LIMIT. If nonempty, only these are candidates.
  2. If QOS_ENABLE, keep candidates whose qos equals the maximum qos among candidates.
  3. Round-robin among survivors: first set index at or above ptr, wrapping modulo S_COUNT.
- RR pointer update: on each ack-release, ptr <= (released index + 1) mod S_COUNT. The index wraps from S_COUNT-1 to 0.
- Age counters, per requester i:
  - Reset to 0 when req[i]=0 or when i is newly granted.
  - Otherwise increment each cycle req[i]=1 and i is not granted.
  - Saturate at AGE_LIMIT; no wrap.
  - Disabled (held 0) when AGE_LIMIT=0.
- Simultaneous events: ack and a new req in the same cycle → the new req participates in that cycle's re-arbitration.
- S_COUNT=1: grant=req registered, held to ack; grant_encoded tied 0.
- Reset mid-grant: grant drops the next cycle regardless of ack. The downstream mux must squash avalid from the reset cycle on.
- Invariant: $onehot0(grant) at all times; grant_valid == |grant.

Decomposition:
- Shared package (axi_xbar_pkg): QOS_W=4, function clog2_min1, function rr_pick(mask, ptr) returning one-hot.
- Sub-module axi_xbar_age_ctr: one instance per requester, parameterised counter with saturate/clear.
- The crossbar's address-decode blocks supply req; the mux consumes grant_encoded.

Test Plan:
- S_COUNT=4, QOS off: req=4'b1111 held, ack every 2nd cycle → grant sequence 0,1,2,3,0…, each held exactly 2 cycles, no bubble.
- QOS on: req=4'b0110, qos1=2, qos2=9 → grant=4'b0100. Ack; raise qos1=9 → grant=4'b0010 (RR tie-break, ptr=3 wraps to 1).
- Aging, AGE_LIMIT=4: req0 qos=0 and req1 qos=15, both held, ack every cycle → req0 granted on the 5th cycle after its age counter hits 4, then req1 resumes.
- Abandon: grant=4'b0001, drop req0 with ack=0 → grant=0 next cycle, ptr unchanged. Ack asserted while idle → no grant appears.
- Reset mid-grant: grant=4'b1000, assert rst one cycle → grant=0, ptr=0, ages=0. Next req=4'b1000 → granted after 1 cycle.
- Back-to-back: ack and req2 rising in the same cycle while req0 is granted → grant=4'b0100 the following cycle.
